// File: rtl/p_det_sequencer.sv
// p_det selector for the CLM parameter extractor: 16-bit Galois LFSR draw with rejection
// sampling and forced acceptance. Define CLM_PDET_NO_REPEAT_EN to forbid consecutive repeats.
module p_det_sequencer #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned MAX_REJ = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        req,
  output logic [4:0]  p_det,
  output logic        valid,
  output logic        busy,
  output logic [7:0]  rej_cnt
);
  typedef logic [4:0] p_det_t;
  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

  localparam logic [15:0] TAPS      = 16'hB400;
  localparam logic [7:0]  MAX_REJ_8 = 8'(MAX_REJ);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_adv;
  logic [7:0]  run_q;
  p_det_t      cand, pick;
  logic        forced, in_range, is_rep, eval, accept;

  function automatic p_det_t fold(input p_det_t c);
    if (c == 5'd0)  return 5'd1;
    if (c == 5'd31) return 5'd30;
    return c;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cand     = lfsr_q[4:0];
  assign lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
  assign forced   = (run_q == MAX_REJ_8);
  assign in_range = (cand != 5'd0) && (cand != 5'd31);
  assign accept   = forced || (in_range && !is_rep);
  // A seed load steals the cycle: no candidate is judged while the LFSR is overwritten.
  assign eval     = (state_q == DRAW) && !seed_load;

`ifdef CLM_PDET_NO_REPEAT_EN
  logic have_prev;

  function automatic p_det_t bump(input p_det_t c);
    return (c == 5'd30) ? 5'd1 : c + 5'd1;
  endfunction

  assign is_rep = have_prev && (cand == p_det);
  assign pick   = (have_prev && (fold(cand) == p_det)) ? bump(fold(cand)) : fold(cand);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 have_prev <= 1'b0;
    else if (eval && accept) have_prev <= 1'b1;
  end
`else
  assign is_rep = 1'b0;
  assign pick   = fold(cand);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: if (req) state_d = DRAW;
      DRAW:       if (eval && accept) state_d = HOLD;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      p_det   <= 5'd1;
      valid   <= 1'b0;
      busy    <= 1'b0;
      rej_cnt <= 8'd0;
      run_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      valid   <= (state_d == HOLD);
      busy    <= (state_d == DRAW);
      if (seed_load)             lfsr_q <= (seed == 16'h0000) ? SEED : seed;
      else if (state_q == DRAW)  lfsr_q <= lfsr_adv;
      if (eval) begin
        if (accept) begin
          p_det <= pick;
          run_q <= 8'd0;
        end else begin
          run_q   <= run_q + 8'd1;
          rej_cnt <= sat_inc(rej_cnt);
        end
      end
    end
  end
endmodule

// File: tb/tb_p_det_sequencer.sv
// Bench for p_det_sequencer: fixed vector table, directed corner sequences and randomized
// draws against a draw-level reference model. Honours CLM_PDET_NO_REPEAT_EN.
module tb_p_det_sequencer;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef CLM_PDET_NO_REPEAT_EN
  localparam bit NR = 1'b1;
`else
  localparam bit NR = 1'b0;
`endif

  logic        clk, rst;
  logic        req[2], seed_load[2];
  logic [15:0] seed[2];
  logic [4:0]  p_det[2];
  logic        valid[2], busy[2];
  logic [7:0]  rej_cnt[2];

  p_det_sequencer #(.SEED(SEED), .MAX_REJ(8)) dut0 (
    .clk(clk), .rst(rst), .seed_load(seed_load[0]), .seed(seed[0]), .req(req[0]),
    .p_det(p_det[0]), .valid(valid[0]), .busy(busy[0]), .rej_cnt(rej_cnt[0]));

  p_det_sequencer #(.SEED(SEED), .MAX_REJ(1)) dut1 (
    .clk(clk), .rst(rst), .seed_load(seed_load[1]), .seed(seed[1]), .req(req[1]),
    .p_det(p_det[1]), .valid(valid[1]), .busy(busy[1]), .rej_cnt(rej_cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_lfsr[2];
  int          m_last[2];
  bit          m_have[2];
  int          m_rej[2];

  typedef struct {
    logic [15:0] seed;
    int          exp_p;
    int          exp_lat;
    int          exp_rej;
  } vec_t;
  vec_t tbl[6];

  function automatic int maxr(input int k);
    return (k == 0) ? 8 : 1;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lfsr[k] = SEED;
      m_last[k] = 1;
      m_have[k] = 1'b0;
      m_rej[k]  = 0;
    end
  endtask

  // One whole draw: walk candidates until one is taken; return value and candidates used.
  task automatic model_draw(input int k, output int p, output int ncand);
    int  run, c, f;
    bit  done;
    run = 0; ncand = 0; p = 0; done = 1'b0;
    while (!done && ncand < 300) begin
      c = int'(m_lfsr[k][4:0]);
      m_lfsr[k] = lfsr_next(m_lfsr[k]);
      ncand++;
      if (run == maxr(k)) begin
        f = (c == 0) ? 1 : ((c == 31) ? 30 : c);
        if (NR && m_have[k] && f == m_last[k]) f = (f == 30) ? 1 : f + 1;
        p = f; done = 1'b1;
      end else if (c >= 1 && c <= 30 && !(NR && m_have[k] && c == m_last[k])) begin
        p = c; done = 1'b1;
      end else begin
        run++;
        if (m_rej[k] < 255) m_rej[k]++;
      end
    end
    m_last[k] = p;
    m_have[k] = 1'b1;
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; seed_load[k] = 1'b0; seed[k] = 16'h0000;
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_seed(input int k, input logic [15:0] s);
    @(negedge clk);
    seed_load[k] = 1'b1; seed[k] = s;
    @(negedge clk);
    seed_load[k] = 1'b0;
    m_lfsr[k] = (s == 16'h0000) ? SEED : s;
  endtask

  task automatic do_draw(input int k, input bit stall, input logic [15:0] sseed,
                         output int p, output int lat);
    int ncand;
    @(negedge clk);
    req[k] = 1'b1;
    @(posedge clk); #1;
    req[k] = 1'b0;
    lat = 1;
    check("busy_in_draw", int'(busy[k]), 1);
    check("valid_in_draw", int'(valid[k]), 0);
    check("pdet_held_in_draw", int'(p_det[k]), m_last[k]);
    if (stall) begin
      @(negedge clk);
      seed_load[k] = 1'b1; seed[k] = sseed;
      @(posedge clk); #1;
      seed_load[k] = 1'b0;
      lat++;
      m_lfsr[k] = (sseed == 16'h0000) ? SEED : sseed;
      check("busy_after_stall", int'(busy[k]), 1);
    end
    model_draw(k, p, ncand);
    while (!valid[k] && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check("valid_done", int'(valid[k]), 1);
    check("p_det", int'(p_det[k]), p);
    check("latency", lat, 1 + ncand + int'(stall));
    check("rej_cnt", int'(rej_cnt[k]), m_rej[k]);
  endtask

  initial begin
    int p, lat;
    logic [15:0] s;
    bit st;
    int k, r;

    tbl[0] = '{16'h0000, 1, 2, 0};
    tbl[1] = '{16'h001F, 15, 3, 1};
    tbl[2] = '{16'hACE1, 1, 2, 0};
    tbl[3] = '{16'h001E, 30, 2, 0};
    tbl[4] = '{16'h0020, 16, 3, 1};
    tbl[5] = '{16'h003F, 15, 4, 2};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; seed_load[i] = 1'b0; seed[i] = 16'h0000;
    end
    #12;
    check("rst_p_det", int'(p_det[0]), 1);
    check("rst_valid", int'(valid[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_rej_cnt", int'(rej_cnt[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Default seed: c=1 accepted after two cycles, busy for exactly one.
    do_draw(0, 1'b0, 16'h0, p, lat);
    check("dflt_p", int'(p_det[0]), 1);
    check("dflt_lat", lat, 2);
    check("dflt_busy_cleared", int'(busy[0]), 0);

    foreach (tbl[i]) begin
      reset_all();
      load_seed(0, tbl[i].seed);
      check("tbl_idle_valid", int'(valid[0]), 0);
      do_draw(0, 1'b0, 16'h0, p, lat);
      check("tbl_p", int'(p_det[0]), tbl[i].exp_p);
      check("tbl_lat", lat, tbl[i].exp_lat);
      check("tbl_rej", int'(rej_cnt[0]), tbl[i].exp_rej);
      @(posedge clk); #1;
      check("tbl_hold_p", int'(p_det[0]), tbl[i].exp_p);
      check("tbl_hold_valid", int'(valid[0]), 1);
    end

    // Repeat rule: reseed to the default state after a draw of 1 and draw again.
    reset_all();
    do_draw(0, 1'b0, 16'h0, p, lat);
    load_seed(0, 16'hACE1);
    check("seed_in_hold_valid", int'(valid[0]), 1);
    do_draw(0, 1'b0, 16'h0, p, lat);
    check("second_draw_p", int'(p_det[0]), NR ? 16 : 1);
    check("second_draw_rej", int'(rej_cnt[0]), NR ? 1 : 0);

    // Forced acceptance on MAX_REJ=1: find a seed giving c=0 twice in a row.
    reset_all();
    s = 16'h0001;
    while (!(s[4:0] == 5'd0 && lfsr_next(s) ? (lfsr_next(s) & 16'h001F) == 16'h0 : 1'b0)) s++;
    load_seed(1, s);
    do_draw(1, 1'b0, 16'h0, p, lat);
    check("forced_p", int'(p_det[1]), 1);
    check("forced_lat", lat, 3);
    check("forced_rej", int'(rej_cnt[1]), 1);

    // Async reset in the middle of a draw discards it.
    reset_all();
    load_seed(0, 16'h001F);
    do_draw(0, 1'b0, 16'h0, p, lat);
    @(negedge clk);
    req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    check("pre_rst_busy", int'(busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_p_det", int'(p_det[0]), 1);
    check("mid_rst_valid", int'(valid[0]), 0);
    check("mid_rst_busy", int'(busy[0]), 0);
    check("mid_rst_rej", int'(rej_cnt[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_draw(0, 1'b0, 16'h0, p, lat);
    check("post_rst_p", int'(p_det[0]), 1);

    // seed_load during DRAW: draw resumes from the loaded state.
    do_draw(0, 1'b1, 16'h001F, p, lat);
    do_draw(1, 1'b1, 16'h0000, p, lat);

    for (int i = 0; i < 10000; i++) begin
      k  = (i % 5 == 0) ? 1 : 0;
      r  = int'($urandom_range(0, 49));
      if (r == 0) load_seed(k, 16'($urandom));
      st = (r == 1);
      do_draw(k, st, 16'($urandom), p, lat);
      check("rand_range", int'(p_det[k] >= 5'd1 && p_det[k] <= 5'd30), 1);
      check("rand_lat_bound", int'(lat <= 2 + maxr(k) + int'(st)), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/p_det_sequencer.md
# p_det_sequencer

Produces the p_det selector consumed by the CLM parameter extraction path: a fresh random field-representation index in 1..30 is drawn per request with a 16-bit Galois LFSR and rejection sampling. The index is then held stable, with a valid flag, until the next request. Sits between the CLM control FSM (request side) and the parameter extractor (p_det consumer). Provides seeding and a bounded-latency fallback so a draw never stalls indefinitely.

## Interface
- SEED, 16'hACE1: LFSR reset value; also substituted whenever an all-zero seed is loaded.
- MAX_REJ, 8: consecutive rejected candidates tolerated before forced acceptance; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- seed_load  in  1  load `seed` into the LFSR this cycle.
- seed  in  16  new LFSR state; 16'h0000 maps to SEED.
- req  in  1  request a new p_det; single-cycle pulse or level.
- p_det  out  5 (p_det_t)  current index, always in 1..30.
- valid  out  1  p_det is a completed draw and stable.
- busy  out  1  draw in progress (state DRAW).
- rej_cnt  out  8  saturating count of rejected candidates since reset (diagnostic).

## Operation
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400. Next state = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
- Candidate: c = lfsr[4:0] of the current state.
- States:
  - IDLE: after reset; valid=0.
  - DRAW: busy=1, valid=0.
  - HOLD: valid=1.
- IDLE/HOLD + req=1 → DRAW. valid drops in the same edge.
- DRAW, each cycle:
  - LFSR advances.
  - c is accepted if 1 ≤ c ≤ 30 (see Configuration). Accept → p_det<=c, valid<=1, go HOLD, rejection run counter cleared.
  - Otherwise reject: run counter +1, rej_cnt +1 saturating at 8'hFF.
- Forced acceptance: when the run counter equals MAX_REJ, the next candidate is folded instead of rejected: 0→1, 31→30. Under the no-repeat rule, a fold equal to the last value is incremented with wrap (30→1).
- req in DRAW: ignored; no queuing.
- seed_load (any state): LFSR <= (seed==0) ? SEED : seed. It takes priority over the DRAW advance in that cycle. DRAW evaluates no candidate that cycle and resumes next cycle from the new state. State and outputs are otherwise unchanged.
- Reset values: state=IDLE, LFSR=SEED, p_det=5'd1 (keeps extractor outputs defined), valid=0, busy=0, rej_cnt=0, run counter=0, have_prev=0.

## Timing
- req sampled at edge t → DRAW from t+1. First candidate evaluated in cycle t+1. If accepted, p_det/valid are updated at edge t+2. Minimum latency is 2 cycles.
- Worst-case latency: 2 + MAX_REJ cycles, excluding seed_load stalls.
- p_det changes only on the DRAW→HOLD edge. It holds its prior value while valid=0 in DRAW.
- All outputs are registered; there are no combinational in→out paths.
- rst mid-DRAW: immediate return to reset values; any partial draw is discarded.

## Configuration
- CLM_PDET_NO_REPEAT_EN defined:
  - A candidate equal to the last issued p_det is rejected, counted, and contributes to the run counter.
  - This applies only when have_prev=1. have_prev is set on the first acceptance.
  - Consecutive draws therefore always differ.
- Undefined: repeats are allowed. have_prev logic and the compare are omitted.

## Test plan
- Reset with default SEED, then req → LFSR 16'hACE1, c=1 accepted; p_det=1, valid=1 two cycles after req. busy high exactly one cycle.
- seed_load with seed=16'h001F, then req:
  - c=31 rejected, then LFSR=16'hB40F gives c=15.
  - p_det=15 at req+3; rej_cnt=1.
- seed_load with seed=16'h0000 → LFSR=16'hACE1; the next draw matches the default-reset result (p_det=1).
- Forced acceptance: MAX_REJ=1, seed such that c=0 then c=0 (bench-computed) → p_det=1 at req+3, never 0 or 31. Randomized 10k draws: p_det always in 1..30, latency ≤ 2+MAX_REJ.
- CLM_PDET_NO_REPEAT_EN: reload seed 16'hACE1 after the first draw gives p_det=1; the second req must yield ≠1 with rej_cnt incremented. Without the macro, the second draw returns 1.
- rst asserted in DRAW and seed_load during DRAW:
  - rst → outputs at reset values asynchronously.
  - seed_load → no candidate evaluated that cycle; result matches a model seeded at that edge.
